// File: rtl/run_event_logger.sv
// Run event logger: tracks qualifying runs from the run detector and
// queues {polarity, length} records in a show-ahead FIFO.
module run_event_logger #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bit_in,
  input  logic                   run_in,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bit,
  output logic [LEN_W-1:0]       out_len,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       run_count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    IN_RUN
  } state_e;

  typedef struct packed {
    logic             pol;
    logic [LEN_W-1:0] len;
  } rec_t;

  state_e           state_q, state_d;
  logic             bit_d_q;
  logic             run_d_q;
  logic             pol_q, pol_d;
  logic [LEN_W-1:0] len_q, len_d;

  rec_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             ovf_q, ovf_d;

  logic             start;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;
  rec_t             wr_rec;
  rec_t             head;

  assign start   = (state_q == IDLE) && run_in && !run_d_q;
  assign push    = (state_q == IN_RUN) && !run_in;
  assign pop     = (cnt_q != '0) && out_ready;
  assign full    = (cnt_q == CW'(DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && !push_ok;
  assign wr_rec  = '{pol: pol_q, len: len_q};

  // Run tracker next state: open on rising run flag, grow, close on fall
  always_comb begin
    state_d = state_q;
    pol_d   = pol_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = IN_RUN;
          pol_d   = bit_d_q;
          len_d   = LEN_W'(3);
        end
      end
      IN_RUN: begin
        if (!run_in) begin
          state_d = IDLE;
        end else if (len_q != '1) begin
          len_d = len_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers/occupancy plus run counter and sticky overflow
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    run_cnt_d = clr ? '0 : run_cnt_q;
    ovf_d     = clr ? 1'b0 : ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (start) run_cnt_d = run_cnt_d + 1'b1;
    if (drop)  ovf_d = 1'b1;
  end

  // Input delay taps and tracker state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_d_q <= 1'b0;
      run_d_q <= 1'b0;
      state_q <= IDLE;
      pol_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      bit_d_q <= bit_in;
      run_d_q <= run_in;
      state_q <= state_d;
      pol_q   <= pol_d;
      len_q   <= len_d;
    end
  end

  // Record storage, cleared so the head never shows X
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_rec;
    end
  end

  // FIFO control, run counter and overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      run_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      run_cnt_q <= run_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (cnt_q != '0);
  assign out_bit    = head.pol;
  assign out_len    = head.len;
  assign fifo_count = cnt_q;
  assign run_count  = run_cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/run_event_logger.md
Name: run_event_logger

Overview:
- Downstream consumer of the three-consecutive-bit run detector. Takes the detector's registered run flag and the same serial bit stream.
- Measures each qualifying run (3 or more identical bits) and records its polarity and total length.
- Queues one record per finished run in a small show-ahead FIFO with a valid/ready output.
- Keeps a running count of runs and a sticky overflow flag for the host/debug side.

Parameters:
- LEN_W, 8: width of the run-length field; lengths saturate at 2^LEN_W-1.
- DEPTH, 4: number of FIFO record entries; must be a power of 2, minimum 2.
- CNT_W, 16: width of the total-run counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- bit_in  input  1  serial bit stream, the same stream the detector samples, same cycle.
- run_in  input  1  detector output; high while a run of 3 or more is in progress (registered, one cycle after the 3rd identical bit).
- clr  input  1  synchronous clear of overflow and run_count. FIFO is untouched.
- out_valid  output  1  FIFO head record is valid.
- out_ready  input  1  consumer accepts the head record when out_valid && out_ready.
- out_bit  output  1  polarity of the head record's run.
- out_len  output  LEN_W  total length of the head record's run, in bits.
- fifo_count  output  $clog2(DEPTH)+1  number of stored records.
- run_count  output  CNT_W  number of runs started since reset or clr.
- overflow  output  1  sticky; set when a record is dropped because the FIFO is full.

Behaviour:
- Reset (asynchronous, reset_n low):
  - out_valid=0, out_bit=0, out_len=0, fifo_count=0, run_count=0, overflow=0.
  - Internal registers cleared: bit_d, run_d, length counter, polarity, FIFO pointers.
  - Reset mid-run abandons the run with no record.
- Registered every cycle: bit_d <= bit_in and run_d <= run_in.
- Tracker FSM:
  - States: IDLE, IN_RUN.
  - IDLE -> IN_RUN when run_in=1 and run_d=0 (rising edge).
    - On entry: polarity <= bit_d (the run bit that completed the triple), len <= 3, run_count <= run_count+1.
  - IN_RUN while run_in=1: len <= len+1, saturating at 2^LEN_W-1.
  - IN_RUN -> IDLE when run_in=0. Push record {polarity, len} in that same cycle.
  - Recorded length = number of cycles run_in was high + 2.
  - Back-to-back runs of opposite polarity always have 2 or more low cycles of run_in between them. No special case is needed, but the FSM must not rely on that gap.
- FIFO:
  - Show-ahead: out_bit/out_len always reflect the head entry. Values are don't-care when out_valid=0 but must not be X after reset.
  - Latency: run_in sampled low at edge n pushes at edge n; out_valid=1 from edge n (visible the cycle after the falling edge) if the FIFO was empty.
  - Pop on out_valid && out_ready.
  - Push accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle; in that case fifo_count is unchanged.
  - Push when full with no pop: record dropped, overflow <= 1, fifo_count stays DEPTH.
  - Pop when empty: ignored.
  - Read and write pointers wrap modulo DEPTH.
  - fifo_count = entries after the edge.
- clr:
  - overflow <= 0 and run_count <= 0.
  - If a run starts in the same cycle as clr, run_count <= 1.
  - If a drop occurs in the same cycle as clr, overflow <= 1 (the event wins).
- Saturated len holds at the maximum until the run ends. The record shows the saturated value.
- run_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset then bits 0,0,0,0,1 with the detector model driving run_in (high 2 cycles) -> one record {out_bit=0, out_len=4}; out_valid rises the cycle after run_in falls; run_count=1.
- Bits 1,1,1,0,0,0,0,0,1 -> two records in order, {1,3} then {0,5}; fifo_count=2 with out_ready=0; run_count=2.
- Generate 5 runs with out_ready=0, DEPTH=4 -> fifo_count=4, overflow=1, the 5th record lost. Then hold out_ready=1 -> the 4 original records drain in order and out_valid drops.
- FIFO full, with out_ready=1 in the same cycle a new run ends -> pop and push both happen, fifo_count stays 4, overflow stays 0.
- LEN_W=3 with run_in held high 10 cycles -> out_len=7 (saturated). Pulse clr mid-stream -> run_count and overflow go to 0 and the FIFO contents are unchanged.
- Assert reset_n low while in IN_RUN with 2 records queued -> all outputs go to 0 immediately. After release, no record for the aborted run, and the next run's record is correct.
